mem_req_ctrl: RTL and testbench

- Request/response sequencer that sits directly upstream of the single-port synchronous RAM.
- Converts a valid/ready request stream (read or write) into the RAM's addr / write_data / write_enable pins.
- Absorbs the RAM's one-cycle registered read latency and returns read data on a valid/ready response channel.
- Optionally sweeps the whole array to zero on command, replacing reliance on the RAM's own reset behaviour.

---
 rtl/mem_req_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request/response sequencer in front of a single-port synchronous RAM with one-cycle read latency.
// Optional whole-array zero sweep on init_start is compiled in with `define CLEAR_SWEEP_EN.
module mem_req_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    RSP
`ifdef CLEAR_SWEEP_EN
    , CLEAR
`endif
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic                  mem_we_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                  accept;

`ifdef CLEAR_SWEEP_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;

  // init_start wins over a same-cycle request, so ready drops with it.
  assign req_ready = reset && (state == IDLE) && !init_start;
  assign init_busy = (state == CLEAR);
`else
  logic unused_init_start;

  assign unused_init_start = init_start;
  assign req_ready = reset && (state == IDLE);
  assign init_busy = 1'b0;
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    state_nxt     = state;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_write_data;
    mem_we_nxt    = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
`ifdef CLEAR_SWEEP_EN
    clr_cnt_nxt   = clr_cnt;
`endif
    case (state)
      IDLE: begin
`ifdef CLEAR_SWEEP_EN
        if (init_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end else
`endif
        if (accept) begin
          mem_addr_nxt = req_addr;
          if (req_write) begin
            mem_wdata_nxt = req_wdata;
            mem_we_nxt    = 1'b1;
          end else begin
            state_nxt = RD_ISSUE;
          end
        end
      end
      // RAM registers the read word on this edge.
      RD_ISSUE: state_nxt = RD_CAPT;
      RD_CAPT: begin
        rsp_rdata_nxt = mem_read_data;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
`ifdef CLEAR_SWEEP_EN
      CLEAR: begin
        mem_addr_nxt  = clr_cnt;
        mem_wdata_nxt = '0;
        mem_we_nxt    = 1'b1;
        clr_cnt_nxt   = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
`ifdef CLEAR_SWEEP_EN
      clr_cnt          <= '0;
`endif
    end else begin
      state            <= state_nxt;
      mem_addr         <= mem_addr_nxt;
      mem_write_data   <= mem_wdata_nxt;
      mem_write_enable <= mem_we_nxt;
      rsp_valid        <= rsp_valid_nxt;
      rsp_rdata        <= rsp_rdata_nxt;
`ifdef CLEAR_SWEEP_EN
      clr_cnt          <= clr_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural single-port RAM (registered read).
// Sweep-specific steps are compiled only when CLEAR_SWEEP_EN is defined.
module tb_mem_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init_start = 1'b0;
  logic          init_busy;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;

  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] ram_q = '0;

  int passed = 0;
  int total  = 0;

  mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_busy(init_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;

  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_addr] <= mem_write_data;
    ram_q <= ram[mem_addr];
  end
  assign mem_read_data = ram_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full read handshake with rsp_ready held high; bounded wait for the response.
  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int n;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1);
    check({tag, "_rdata"}, rsp_rdata, exp);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int cnt;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_we", mem_write_enable, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_init_busy", init_busy, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    // Single write 0x005 = 0xA5
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h005; req_wdata = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    check("wr1_we", mem_write_enable, 1);
    check("wr1_addr", mem_addr, 10'h005);
    check("wr1_data", mem_write_data, 8'hA5);
    check("wr1_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("wr1_we_pulse", mem_write_enable, 0);
    check("wr1_addr_hold", mem_addr, 10'h005);
    check("wr1_rsp_valid2", rsp_valid, 0);

    // Write 0x3FF = 0x5A then read it on the very next cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h3FF; req_wdata = 8'h5A;
    @(negedge clk);
    check("raw_we", mem_write_enable, 1);
    check("raw_rd_ready", req_ready, 1);
    req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("raw_busy_ready", req_ready, 0);
    check("raw_rd_we", mem_write_enable, 0);
    check("raw_rd_addr", mem_addr, 10'h3FF);
    check("raw_lat1", rsp_valid, 0);
    @(negedge clk);
    check("raw_lat2", rsp_valid, 0);
    @(negedge clk);
    check("raw_lat3", rsp_valid, 1);
    check("raw_rdata", rsp_rdata, 8'h5A);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("raw_rsp_done", rsp_valid, 0);
    check("raw_ready_back", req_ready, 1);

    // Read 0x005 with back-pressure for 10 cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h005;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, 8'hA5);
      check("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ready_after", req_ready, 1);
    check("bp_valid_after", rsp_valid, 0);

    // Four back-to-back writes 0x010..0x013 = 0x01..0x04
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = 10'h010; req_wdata = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("b2b_we", mem_write_enable, 1);
      check("b2b_addr", mem_addr, 32'h010 + i - 1);
      check("b2b_data", mem_write_data, i);
      req_addr = AW'(10'h010 + i);
      req_wdata = DW'(i + 1);
      if (i == 4) req_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_we_end", mem_write_enable, 0);
    do_read("rd_010", 10'h010, 8'h01);
    do_read("rd_011", 10'h011, 8'h02);
    do_read("rd_012", 10'h012, 8'h03);
    do_read("rd_013", 10'h013, 8'h04);

    // Reset in the middle of a read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h010;
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_we", mem_write_enable, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_busy", init_busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    check("post_rst_ready", req_ready, 1);
    do_read("rd_3ff_kept", 10'h3FF, 8'h5A);

`ifdef CLEAR_SWEEP_EN
    // Fill 0x005 = 0xFF, then init_start collides with a write request
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h005; req_wdata = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    do_read("rd_005_ff", 10'h005, 8'hFF);
    init_start = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h021; req_wdata = 8'h33;
    #1 check("clr_req_blocked", req_ready, 0);
    @(negedge clk);
    init_start = 1'b0; req_valid = 1'b0;
    check("clr_no_write", mem_write_enable, 0);
    cnt = 0;
    while (init_busy && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check("clr_busy_cycles", cnt, DEPTH);
    check("clr_ready_back", req_ready, 1);
    @(negedge clk);
    do_read("rd_005_clr", 10'h005, 8'h00);
    do_read("rd_3ff_clr", 10'h3FF, 8'h00);
    do_read("rd_021_clr", 10'h021, 8'h00);
`else
    // Without the sweep, init_start must not block or disturb a request
    init_start = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020; req_wdata = 8'h77;
    #1 check("nosweep_ready", req_ready, 1);
    @(negedge clk);
    init_start = 1'b0; req_valid = 1'b0;
    check("nosweep_we", mem_write_enable, 1);
    check("nosweep_addr", mem_addr, 10'h020);
    check("nosweep_busy", init_busy, 0);
    @(negedge clk);
    check("nosweep_busy2", init_busy, 0);
    do_read("rd_020", 10'h020, 8'h77);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
